alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Two-requester controller that time-shares the single 32-bit datapath ALU and its result register. It arbitrates between requesters with round-robin priority and drives the ALU operands and opcode from internally latched copies. It captures the ALU result and returns it with a valid/ready handshake tagged by requester ID. It sits between the instruction-issue logic (requester 0) and the address/branch-compute path (requester 1) on one side and the shared ALU on the other.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 4, ALU opcode width (opaque to this block)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; at most one bit high
- req_op0 / req_op1  in  OP_W  opcode from requester 0 / 1
- req_a0, req_b0 / req_a1, req_b1  in  DATA_W  operands from requester 0 / 1
- alu_a, alu_b  out  DATA_W  operands to the shared ALU
- alu_op  out  OP_W  opcode to the shared ALU
- alu_result  in  DATA_W  combinational ALU result
- alu_zero  in  1  combinational ALU zero flag
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  1  requester that owns the result
- resp_data  out  DATA_W  latched ALU result
- resp_zero  out  1  latched zero flag
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid is set, the arbiter picks the winner i and asserts req_ready[i] combinationally in the same cycle. Opcode and operands of requester i are latched and the winner ID is recorded. Next state is EXEC. If no req_valid is set, stay in IDLE.
- Arbitration: if only one requester is valid, it wins. If both are valid, the winner is the requester that was not granted last. The last_grant register updates only on an accept.
- EXEC: alu_a, alu_b and alu_op are driven from the latched copies. At the clock edge, alu_result and alu_zero are captured into resp_data and resp_zero. Next state is RESP.
- RESP: resp_valid=1. resp_id, resp_data and resp_zero are held stable. On resp_ready=1, go to IDLE. Otherwise stay in RESP indefinitely.
- req_ready is 0 in EXEC and RESP. Requests present in those states are not accepted and must be held by the requester.
- alu_a, alu_b and alu_op hold their last driven values outside EXEC. They carry no meaning when busy=0.
- No width conversion: results pass through at DATA_W bits. The opcode is not decoded.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_zero=0, alu_a=0, alu_b=0, alu_op=0, busy=0. State=IDLE. last_grant=1, so requester 0 wins the first contention.
- Latency: accept in cycle N (IDLE), ALU evaluates in N+1 (EXEC), resp_valid=1 from N+2.
- Peak throughput: one operation per 3 cycles when resp_ready is held at 1.
- Simultaneous resp_ready and a new request: the response completes and the FSM enters IDLE. The new request is accepted in the following cycle. There is no bypass.
- Reset during EXEC or RESP: the in-flight operation is dropped and no response is issued. All outputs return to reset values in the next cycle.
- Reset has priority over every other event.

## Configuration
- ALU_SHARE_STATS_EN defined: two extra outputs, grant_cnt0 and grant_cnt1 (16 bits each).
  - Each increments on an accept for its requester and saturates at 16'hFFFF.
  - Both clear to 0 on reset.
- ALU_SHARE_STATS_EN undefined: the counters and ports are absent. All other behaviour is identical.

## Structure
- Package alu_share_pkg holds:
  - the state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2)
  - the DATA_W and OP_W defaults
  - the stats counter width (16)
- Sub-module rr_arb2 holds the two-input round-robin arbiter: inputs req[1:0], en, clk, reset; output gnt[1:0], one-hot or zero. last_grant lives inside it and is updated when en is high and gnt is nonzero.

## Test plan
- Single request: req_valid=2'b01, a=32'd7, b=32'd5, op=ADD, ALU model adds → req_ready=2'b01 in cycle 0; resp_valid in cycle 2 with resp_data=32'd12, resp_id=0, resp_zero=0.
- Contention: both valid continuously, resp_ready=1 → grants alternate 0,1,0,1, one every 3 cycles. resp_id sequence is 0,1,0,1.
- Backpressure: resp_ready=0 for 5 cycles in RESP → resp_valid, resp_data and resp_id stay stable, req_ready=2'b00 throughout. resp_ready=1 then returns the FSM to IDLE in the next cycle.
- Zero flag: a=b=32'hFFFF_FFFF, op=SUB → resp_data=0, resp_zero=1.
- Reset mid-operation: assert reset in EXEC → no resp_valid is seen; all outputs are 0 the next cycle; the next contention is won by requester 0.
- With ALU_SHARE_STATS_EN: issue 3 requests on requester 1 → grant_cnt1=3, grant_cnt0=0. Force a counter to 16'hFFFF, grant again → it stays at 16'hFFFF.

Source files
------------

// File: rtl/alu_share_pkg.sv
// Shared types and defaults for the two-requester ALU sharing controller.
// Optional grant statistics are enabled with the ALU_SHARE_STATS_EN macro.
package alu_share_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 4;
  localparam int STAT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
    if (val == {STAT_W{1'b1}}) begin
      return val;
    end
    return val + 1'b1;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; on contention the requester not granted last wins.
// last_grant resets to 1 so requester 0 wins the first contention.
module rr_arb2
  import alu_share_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    last_grant_d = last_grant_q;
    if (gnt != 2'b00) begin
      last_grant_d = gnt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one ALU between two requesters: accept, execute, then hold the tagged result.
// Define ALU_SHARE_STATS_EN to add saturating per-requester grant counters.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_zero,
  output logic              busy
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
`endif
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_zero_q, resp_zero_d;
  logic              busy_q, busy_d;
  logic [1:0]        gnt;
  logic              arb_en;
`ifdef ALU_SHARE_STATS_EN
  logic [STAT_W-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [STAT_W-1:0] grant_cnt1_q, grant_cnt1_d;
`endif

  // Grants are only offered while idle and never in a reset cycle.
  assign arb_en = (state_q == IDLE) && !reset;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   (req_valid),
    .gnt   (gnt)
  );

  assign req_ready  = gnt;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_zero  = resp_zero_q;
  assign busy       = busy_q;
`ifdef ALU_SHARE_STATS_EN
  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_zero_d  = resp_zero_q;
    busy_d       = busy_q;
`ifdef ALU_SHARE_STATS_EN
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
`endif
    case (state_q)
      IDLE: begin
        // The latched operands drive the ALU directly and persist after the operation.
        if (gnt != 2'b00) begin
          state_d   = EXEC;
          busy_d    = 1'b1;
          resp_id_d = gnt[1];
          alu_op_d  = gnt[1] ? req_op1 : req_op0;
          alu_a_d   = gnt[1] ? req_a1  : req_a0;
          alu_b_d   = gnt[1] ? req_b1  : req_b0;
`ifdef ALU_SHARE_STATS_EN
          if (gnt[1]) begin
            grant_cnt1_d = sat_inc(grant_cnt1_q);
          end else begin
            grant_cnt0_d = sat_inc(grant_cnt0_q);
          end
`endif
        end
      end
      EXEC: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_data_d  = alu_result;
        resp_zero_d  = alu_zero;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          busy_d       = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ALU_SHARE_STATS_EN
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_zero_q  <= resp_zero_d;
      busy_q       <= busy_d;
`ifdef ALU_SHARE_STATS_EN
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized self-checking bench for alu_share_ctrl against a transaction-level model.
// Grant counter checks are compiled in when ALU_SHARE_STATS_EN is defined.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_data;
  logic        resp_zero;
  logic        busy;
`ifdef ALU_SHARE_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  // Requester-side operand storage, held until the request is accepted.
  logic [3:0]  r_op [2];
  logic [31:0] r_a  [2];
  logic [31:0] r_b  [2];

  assign req_op0 = r_op[0];
  assign req_op1 = r_op[1];
  assign req_a0  = r_a[0];
  assign req_b0  = r_b[0];
  assign req_a1  = r_a[1];
  assign req_b1  = r_b[1];

  // Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass a.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == 32'd0);

  alu_share_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_zero  (resp_zero),
    .busy       (busy)
`ifdef ALU_SHARE_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  int vectors    = 0;
  int miscompares = 0;

  // Transaction-level model: one operation in flight, age counts cycles since accept.
  bit          m_inflight = 1'b0;
  int          m_age      = 0;
  bit          m_last     = 1'b1;
  bit          m_id;
  logic [31:0] m_data, m_a, m_b;
  logic [3:0]  m_op;
  bit          m_zero;
  logic [15:0] m_cnt [2];
  int          acc_id;
  logic [1:0]  obs_ready;
  int          cycle_no = 0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cycle_no);
    end
  endtask

  task automatic randomizeReq(input int w);
    r_op[w] = 4'($urandom_range(0, 5));
    r_a[w]  = $urandom;
    r_b[w]  = ($urandom_range(0, 3) == 0) ? r_a[w] : $urandom;
  endtask

  // Called at a negedge: drive, check, advance the model over one posedge, return at next negedge.
  task automatic applyStimulus(input logic [1:0] valid, input logic rready, input logic rst);
    logic [1:0] exp_ready;
    int w;
    req_valid  = valid;
    resp_ready = rready;
    reset      = rst;
    #1;
    obs_ready = req_ready;
    exp_ready = 2'b00;
    if (!m_inflight && !rst) begin
      if (valid == 2'b11) exp_ready = m_last ? 2'b01 : 2'b10;
      else                exp_ready = valid;
    end
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("busy", 32'(busy), 32'(m_inflight));
    checkOutput("resp_valid", 32'(resp_valid), 32'(m_inflight && m_age == 2));
    if (m_inflight && m_age == 2) begin
      checkOutput("resp_id", 32'(resp_id), 32'(m_id));
      checkOutput("resp_data", resp_data, m_data);
      checkOutput("resp_zero", 32'(resp_zero), 32'(m_zero));
    end
    if (m_inflight && m_age == 1) begin
      checkOutput("alu_a", alu_a, m_a);
      checkOutput("alu_b", alu_b, m_b);
      checkOutput("alu_op", 32'(alu_op), 32'(m_op));
    end
`ifdef ALU_SHARE_STATS_EN
    checkOutput("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt[0]));
    checkOutput("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt[1]));
`endif
    acc_id = -1;
    @(posedge clk);
    cycle_no++;
    if (rst) begin
      m_inflight = 1'b0;
      m_last     = 1'b1;
      m_cnt[0]   = 16'd0;
      m_cnt[1]   = 16'd0;
    end else if (exp_ready != 2'b00) begin
      w          = exp_ready[1] ? 1 : 0;
      acc_id     = w;
      m_inflight = 1'b1;
      m_age      = 1;
      m_last     = exp_ready[1];
      m_id       = exp_ready[1];
      m_op       = r_op[w];
      m_a        = r_a[w];
      m_b        = r_b[w];
      m_data     = alu_fn(r_op[w], r_a[w], r_b[w]);
      m_zero     = (m_data == 32'd0);
      if (m_cnt[w] != 16'hFFFF) m_cnt[w] = m_cnt[w] + 16'd1;
    end else if (m_inflight) begin
      if (m_age == 2) begin
        if (rready) m_inflight = 1'b0;
      end else begin
        m_age++;
      end
    end
    @(negedge clk);
  endtask

  task automatic checkResetState();
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_id", 32'(resp_id), 32'd0);
    checkOutput("rst_resp_data", resp_data, 32'd0);
    checkOutput("rst_resp_zero", 32'(resp_zero), 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
  endtask

  task automatic drain();
    repeat (3) applyStimulus(2'b00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [1:0]  exp_gnt;
    int          last_cyc;
    logic        held_id;
    logic [31:0] held_data;
    logic [1:0]  pend;

    m_cnt[0] = 16'd0;
    m_cnt[1] = 16'd0;
    for (int i = 0; i < 2; i++) randomizeReq(i);
    reset      = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkResetState();

    // Contention from reset: grants alternate 0,1,0,1 every third cycle.
    exp_gnt  = 2'b01;
    last_cyc = -1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(2'b11, 1'b1, 1'b0);
      if (obs_ready != 2'b00) begin
        checkOutput("cont_grant", 32'(obs_ready), 32'(exp_gnt));
        if (last_cyc >= 0) checkOutput("cont_gap", 32'(cycle_no - last_cyc), 32'd3);
        last_cyc = cycle_no;
        exp_gnt  = ~exp_gnt;
        randomizeReq(acc_id);
      end
    end
    drain();

    // Single request 7 + 5.
    r_op[0] = 4'd0; r_a[0] = 32'd7; r_b[0] = 32'd5;
    applyStimulus(2'b01, 1'b1, 1'b0);
    checkOutput("single_ready", 32'(obs_ready), 32'd1);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("single_valid", 32'(resp_valid), 32'd1);
    checkOutput("single_data", resp_data, 32'd12);
    checkOutput("single_id", 32'(resp_id), 32'd0);
    checkOutput("single_zero", 32'(resp_zero), 32'd0);
    drain();

    // Backpressure: response held five cycles with both requesters waiting.
    randomizeReq(0);
    randomizeReq(1);
    applyStimulus(2'b01, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b0);
    held_id   = resp_id;
    held_data = resp_data;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b11, 1'b0, 1'b0);
      checkOutput("bp_ready", 32'(obs_ready), 32'd0);
      checkOutput("bp_data", resp_data, held_data);
      checkOutput("bp_id", 32'(resp_id), 32'(held_id));
    end
    applyStimulus(2'b11, 1'b1, 1'b0);
    checkOutput("bp_release_busy", 32'(busy), 32'd0);
    checkOutput("bp_release_valid", 32'(resp_valid), 32'd0);
    drain();

    // Zero flag from all-ones minus all-ones.
    r_op[1] = 4'd1; r_a[1] = 32'hFFFF_FFFF; r_b[1] = 32'hFFFF_FFFF;
    applyStimulus(2'b10, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("zero_data", resp_data, 32'd0);
    checkOutput("zero_flag", 32'(resp_zero), 32'd1);
    drain();

    // Reset while executing: operation dropped, arbiter priority restored.
    randomizeReq(0);
    applyStimulus(2'b01, 1'b1, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b1);
    checkResetState();
    applyStimulus(2'b00, 1'b1, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b0);
    checkOutput("rst_contention", 32'(obs_ready), 32'd1);
    drain();

`ifdef ALU_SHARE_STATS_EN
    applyStimulus(2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      randomizeReq(1);
      applyStimulus(2'b10, 1'b1, 1'b0);
      drain();
    end
    checkOutput("stats_cnt1", 32'(grant_cnt1), 32'd3);
    checkOutput("stats_cnt0", 32'(grant_cnt0), 32'd0);
    force dut.grant_cnt1_q = 16'hFFFF;
    #1;
    release dut.grant_cnt1_q;
    m_cnt[1] = 16'hFFFF;
    applyStimulus(2'b10, 1'b1, 1'b0);
    drain();
    checkOutput("stats_sat", 32'(grant_cnt1), 32'h0000_FFFF);
`endif

    // Randomized traffic with held requests, random backpressure and occasional reset.
    pend = 2'b00;
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          randomizeReq(r);
        end
      end
      applyStimulus(pend, ($urandom_range(0, 3) != 0), ($urandom_range(0, 79) == 0));
      if (acc_id >= 0) begin
        pend[acc_id] = 1'($urandom_range(0, 1));
        if (pend[acc_id]) randomizeReq(acc_id);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
